// File: rtl/exc_sequencer.sv
// CP0 exception sequencer: owns Status/Cause/EPC and cpu_mode. Flushes and stalls the pipeline
// after a taken exception, interrupt or eret, then redirects the PC.
module exc_sequencer #(
  parameter logic [31:0] EXC_VECTOR   = 32'h8000_0180,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  input  logic        exc_ri,
  input  logic        exc_sys,
  input  logic        exc_ret,
  input  logic [31:0] exc_pc,
  input  logic        irq,
  input  logic        cowrite,
  input  logic [4:0]  co_addr,
  input  logic [31:0] co_wdata,
  output logic [31:0] co_rdata,
  output logic        cpu_mode,
  output logic        flush,
  output logic        stall,
  output logic        pc_redirect,
  output logic [31:0] pc_target
);

  localparam logic [3:0] FlushLast = 4'(FLUSH_CYCLES);

  typedef enum logic [1:0] {StIdle, StFlush, StRedirect} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  status_q, status_d;  // {PKM, KM, IE}
  logic [4:0]  code_q, code_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] target_q, target_d;

  logic       ie, km, pkm;
  logic       take_ri, take_sys, take_irq, take_ret, take_exc;
  logic [4:0] exc_code;

  assign ie  = status_q[0];
  assign km  = status_q[1];
  assign pkm = status_q[2];

  always_comb begin
    take_ri  = instr_valid & exc_ri;
    take_sys = instr_valid & exc_sys;
    take_irq = irq & ie & ~km;
    take_ret = instr_valid & exc_ret & km;
    take_exc = take_ri | take_sys | take_irq;
    if (take_ri) begin
      exc_code = 5'd10;
    end else if (take_sys) begin
      exc_code = 5'd8;
    end else begin
      exc_code = 5'd0;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    status_d = status_q;
    code_d   = code_q;
    epc_d    = epc_q;
    target_d = target_q;
    unique case (state_q)
      StIdle: begin
        if (take_exc) begin
          epc_d    = exc_pc;
          code_d   = exc_code;
          status_d = {km, 1'b1, 1'b0};
          target_d = EXC_VECTOR;
          state_d  = StFlush;
          cnt_d    = 4'd1;
        end else if (take_ret) begin
          status_d = {pkm, pkm, 1'b1};
          target_d = epc_q;
          state_d  = StFlush;
          cnt_d    = 4'd1;
        end else if (instr_valid && cowrite && km) begin
          // Only reached when no event is taken, so an event always drops the write.
          case (co_addr)
            5'd12:   status_d = co_wdata[2:0];
            5'd13:   code_d   = co_wdata[6:2];
            5'd14:   epc_d    = co_wdata;
            default: ;
          endcase
        end
      end
      StFlush: begin
        if (cnt_q < FlushLast) begin
          cnt_d = cnt_q + 4'd1;
        end else begin
          state_d = StRedirect;
        end
      end
      StRedirect: state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= 4'd0;
      status_q <= 3'b010;
      code_q   <= 5'd0;
      epc_q    <= 32'h0;
      target_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      status_q <= status_d;
      code_q   <= code_d;
      epc_q    <= epc_d;
      target_q <= target_d;
    end
  end

  assign cpu_mode    = status_q[1];
  assign flush       = (state_q != StIdle);
  assign stall       = (state_q == StFlush);
  assign pc_redirect = (state_q == StRedirect);
  assign pc_target   = target_q;

  always_comb begin
    case (co_addr)
      5'd12:   co_rdata = {29'h0, status_q};
      5'd13:   co_rdata = {25'h0, code_q, 2'b00};
      5'd14:   co_rdata = epc_q;
      default: co_rdata = 32'h0;
    endcase
  end

endmodule
